// File: rtl/usage_monitor_pkg.sv
// Shared sizing and saturating-count helpers for usage_monitor.
// Pure functions and constants; no state, no latency, no flow control.
package usage_monitor_pkg;

  localparam int MAX_CNT_W = 32;

  function automatic int tmr_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  function automatic logic [MAX_CNT_W-1:0] cnt_max(input int width);
    if (width >= MAX_CNT_W) return '1;
    return (MAX_CNT_W'(1) << width) - MAX_CNT_W'(1);
  endfunction

  // Holds at the width's all-ones value instead of wrapping.
  function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] value,
                                                   input logic                 inc,
                                                   input int                   width);
    if (inc && (value != cnt_max(width))) return value + MAX_CNT_W'(1);
    return value;
  endfunction

endpackage

// File: rtl/usage_monitor_if.sv
// MCU-facing bundle of usage_monitor: channel pulses, window control and read port.
// rd_peak exists only when USAGE_MONITOR_PEAK_EN is defined; no backpressure on any signal.
interface usage_monitor_if #(
  parameter int NCHAN = 4,
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
);
  localparam int SEL_W = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  logic [NCHAN-1:0] observable_pulse;
  logic             sample_enable;
  logic [WIN_W-1:0] window_len;
  logic             counter_reset;
  logic [SEL_W-1:0] chan_sel;
  logic [CNT_W-1:0] rd_data;
  logic             window_done;
  logic [NCHAN-1:0] overflow;
`ifdef USAGE_MONITOR_PEAK_EN
  logic             rd_peak;

  modport master (output observable_pulse, sample_enable, window_len, counter_reset, chan_sel, rd_peak,
                  input  rd_data, window_done, overflow);
  modport slave  (input  observable_pulse, sample_enable, window_len, counter_reset, chan_sel, rd_peak,
                  output rd_data, window_done, overflow);
`else
  modport master (output observable_pulse, sample_enable, window_len, counter_reset, chan_sel,
                  input  rd_data, window_done, overflow);
  modport slave  (input  observable_pulse, sample_enable, window_len, counter_reset, chan_sel,
                  output rd_data, window_done, overflow);
`endif

endinterface

// File: rtl/usage_channel.sv
// One monitored channel: idle timer, saturating live busy count, window snapshot, overflow (+ peak under USAGE_MONITOR_PEAK_EN).
// Pulse affects busy the following cycle; snapshot/overflow update on the closing sample; no backpressure.
module usage_channel
  import usage_monitor_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 5
) (
  input  logic             sysclk,
  input  logic             sysreset,
  input  logic             pulse,
  input  logic             sample_enable,
  input  logic             win_close,
  input  logic             counter_reset,
  output logic [CNT_W-1:0] live,
  output logic [CNT_W-1:0] snapshot,
  output logic             overflow
`ifdef USAGE_MONITOR_PEAK_EN
  ,
  output logic [CNT_W-1:0] peak
`endif
);

  localparam int               TW      = tmr_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  logic [TW-1:0]    timer;
  logic             busy;
  logic [CNT_W-1:0] live_next;
  logic             sat_next;

  // busy comes from the registered timer, so a same-cycle pulse never masks the sample.
  assign busy      = (timer == '0);
  assign live_next = CNT_W'(sat_inc(MAX_CNT_W'(live), sample_enable && busy, CNT_W));
  assign sat_next  = (live_next == CNT_MAX);

  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      timer <= '0;
    end else if (pulse) begin
      timer <= TW'(TIMEOUT);
    end else if (!busy) begin
      timer <= timer - TW'(1);
    end
  end

  always_ff @(posedge sysclk) begin
    if (sysreset || counter_reset) begin
      live     <= '0;
      snapshot <= '0;
      overflow <= 1'b0;
    end else if (win_close) begin
      snapshot <= live_next;
      live     <= '0;
      overflow <= sat_next;
    end else begin
      live <= live_next;
      if (sat_next) overflow <= 1'b1;
    end
  end

`ifdef USAGE_MONITOR_PEAK_EN
  always_ff @(posedge sysclk) begin
    if (sysreset || counter_reset) begin
      peak <= '0;
    end else if (win_close && (live_next > peak)) begin
      peak <= live_next;
    end
  end
`endif

endmodule

// File: rtl/usage_monitor.sv
// Windowed multi-channel busy monitor: shared sample/window counter plus per-channel usage_channel (USAGE_MONITOR_PEAK_EN adds peak read).
// rd_data is registered, 1 cycle after chan_sel; window_done pulses the cycle after a close; no backpressure.
module usage_monitor
  import usage_monitor_pkg::*;
#(
  parameter int NCHAN   = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 5,
  parameter int WIN_W   = 16
) (
  input logic           sysclk,
  input logic           sysreset,
  usage_monitor_if.slave bus
);

  localparam int SEL_W = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int NSEL  = 1 << SEL_W;

  logic [WIN_W-1:0] sample_cnt;
  logic             windowing;
  logic             close_hit;
  logic             win_close;
  logic             window_done_q;
  logic [CNT_W-1:0] live_v [NSEL];
  logic [CNT_W-1:0] snap_v [NSEL];
  logic [NCHAN-1:0] ovf_v;
  logic [CNT_W-1:0] rd_next;
  logic [CNT_W-1:0] rd_q;
`ifdef USAGE_MONITOR_PEAK_EN
  logic [CNT_W-1:0] peak_v [NSEL];
`endif

  // >= rather than == so shrinking window_len mid-window closes on the next sample.
  assign windowing = (bus.window_len != '0);
  assign close_hit = windowing && (sample_cnt >= (bus.window_len - WIN_W'(1)));
  assign win_close = bus.sample_enable && close_hit && !bus.counter_reset;

  always_ff @(posedge sysclk) begin
    if (sysreset || bus.counter_reset || !windowing) begin
      sample_cnt <= '0;
    end else if (bus.sample_enable) begin
      sample_cnt <= close_hit ? '0 : sample_cnt + WIN_W'(1);
    end
  end

  always_ff @(posedge sysclk) begin
    if (sysreset) window_done_q <= 1'b0;
    else          window_done_q <= win_close;
  end

  // Unpopulated select codes read as zero.
  for (genvar i = 0; i < NSEL; i++) begin : g_chan
    if (i < NCHAN) begin : g_live
      usage_channel #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
      ) u_chan (
        .sysclk        (sysclk),
        .sysreset      (sysreset),
        .pulse         (bus.observable_pulse[i]),
        .sample_enable (bus.sample_enable),
        .win_close     (win_close),
        .counter_reset (bus.counter_reset),
        .live          (live_v[i]),
        .snapshot      (snap_v[i]),
        .overflow      (ovf_v[i])
`ifdef USAGE_MONITOR_PEAK_EN
        ,
        .peak          (peak_v[i])
`endif
      );
    end else begin : g_pad
      assign live_v[i] = '0;
      assign snap_v[i] = '0;
`ifdef USAGE_MONITOR_PEAK_EN
      assign peak_v[i] = '0;
`endif
    end
  end

  always_comb begin
    rd_next = windowing ? snap_v[bus.chan_sel] : live_v[bus.chan_sel];
`ifdef USAGE_MONITOR_PEAK_EN
    if (bus.rd_peak) rd_next = peak_v[bus.chan_sel];
`endif
  end

  always_ff @(posedge sysclk) begin
    if (sysreset) rd_q <= '0;
    else          rd_q <= rd_next;
  end

  assign bus.rd_data     = rd_q;
  assign bus.window_done = window_done_q;
  assign bus.overflow    = ovf_v;

endmodule
